// File: rtl/pipe_mode_ctrl.sv
// Frame-synchronous filter-pipeline mode controller: swaps mode at EOF, flushes stages, muxes pixel source.
// Latency: pixel mux 1 cycle registered; oMODE/oFRAME_CNT update the cycle after EOF.
// Backpressure: none; a free-running pixel stream, so data is never stalled, only dropped while flushing.
module pipe_mode_ctrl #(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 960,
    parameter int FLUSH_CYC = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [1:0]  iMODE_REQ,
    input  logic        iMODE_STB,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic        iDVAL,
    input  logic [11:0] iRAW,
    input  logic [11:0] iGREY,
    input  logic        iGREY_DVAL,
    input  logic [11:0] iCONV,
    input  logic        iCONV_DVAL,
    output logic [1:0]  oMODE,
    output logic        oCONV_DIR,
    output logic        oPIPE_CLR_n,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oBUSY,
    output logic [15:0] oFRAME_CNT,
    output logic        oERR
);

    // Flush countdown is loaded with FLUSH_CYC-1 and runs down to zero, so
    // FLUSH lasts exactly FLUSH_CYC cycles.
    localparam int                CNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // One extra bit so IMG_W/IMG_H of exactly 2048 would still compare correctly.
    localparam logic [11:0] W_LIM  = 12'(IMG_W);
    localparam logic [11:0] H_LIM  = 12'(IMG_H);
    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_RUN      = 2'd1,
        ST_PEND     = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        next_mode_q, next_mode_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [11:0]       data_q, data_d;
    logic              dval_q, dval_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;

    logic              sof;
    logic              eof;
    logic              coord_bad;
    logic              pend_eff;
    logic [1:0]        next_eff;
    logic              mux_en;
    logic [11:0]       sel_dat;
    logic              sel_vld;

    // Frame markers and range check on the incoming pixel coordinates.
    assign sof       = iDVAL && (iX_Cont == 11'd0)   && (iY_Cont == 11'd0);
    assign eof       = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);
    assign coord_bad = iDVAL && (({1'b0, iX_Cont} >= W_LIM) || ({1'b0, iY_Cont} >= H_LIM));

    // A strobe in this cycle overrides the stored request, so a strobe that
    // lands exactly on EOF is the one that gets applied at that EOF.
    assign pend_eff = iMODE_STB ? (iMODE_REQ != mode_q) : pend_q;
    assign next_eff = iMODE_STB ? iMODE_REQ : next_mode_q;

    // The SOF pixel itself must pass, so the mux is also open on the SOF cycle
    // of WAIT_SOF; a SOF seen while flushing is ignored and its frame dropped.
    assign mux_en = (state_q == ST_RUN) || (state_q == ST_PEND) ||
                    ((state_q == ST_WAIT_SOF) && sof);

    // Next-state logic: request tracking, mode swap at EOF, flush countdown, frame count.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        next_mode_d = next_eff;
        pend_d      = pend_eff;
        flush_cnt_d = flush_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_WAIT_SOF: begin
                if (sof) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (eof) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                if (eof && pend_eff) begin
                    state_d     = ST_FLUSH;
                    mode_d      = next_eff;
                    pend_d      = 1'b0;
                    flush_cnt_d = CNT_LOAD;
                end else if (pend_eff) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (eof) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                if (eof && pend_eff) begin
                    state_d     = ST_FLUSH;
                    mode_d      = next_eff;
                    pend_d      = 1'b0;
                    flush_cnt_d = CNT_LOAD;
                end else if (!pend_eff) begin
                    // Re-request of the active mode cancelled the change.
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_WAIT_SOF;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_WAIT_SOF;
            end
        endcase
    end

    // Source select for the active mode; edge-X and edge-Y share the convolution stage.
    always_comb begin
        sel_dat = iRAW;
        sel_vld = iDVAL;
        case (mode_q)
            2'd0: begin
                sel_dat = iRAW;
                sel_vld = iDVAL;
            end
            2'd1: begin
                sel_dat = iGREY;
                sel_vld = iGREY_DVAL;
            end
            default: begin
                sel_dat = iCONV;
                sel_vld = iCONV_DVAL;
            end
        endcase
    end

    // Output pixel register input: data holds when nothing valid is selected.
    always_comb begin
        dval_d = mux_en && sel_vld;
        data_d = (mux_en && sel_vld) ? sel_dat : data_q;
        err_d  = err_q || coord_bad;
    end

    // FSM state and flush counter.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= ST_WAIT_SOF;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Mode/request registers, output pixel register, frame counter and sticky error.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mode_q      <= 2'd0;
            next_mode_q <= 2'd0;
            pend_q      <= 1'b0;
            data_q      <= 12'd0;
            dval_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            next_mode_q <= next_mode_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            dval_q      <= dval_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // The clear comes straight off the state register, so it is glitch-free and
    // snaps back high the moment reset forces WAIT_SOF.
    assign oMODE       = mode_q;
    assign oCONV_DIR   = mode_q[1] & mode_q[0];
    assign oPIPE_CLR_n = (state_q != ST_FLUSH);
    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oBUSY       = pend_q || (state_q == ST_FLUSH);
    assign oFRAME_CNT  = frame_cnt_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_pipe_mode_ctrl.sv
// Self-checking bench for pipe_mode_ctrl on an 8x4 frame with a 16-cycle flush.
// Latency: every cycle is compared one cycle after the inputs are applied.
// Backpressure: none; the bench drives a free-running pixel stream.
module tb_pipe_mode_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FC = 16;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [1:0]  iMODE_REQ = 2'd0;
    logic        iMODE_STB = 1'b0;
    logic [10:0] iX_Cont = 11'd0;
    logic [10:0] iY_Cont = 11'd0;
    logic        iDVAL = 1'b0;
    logic [11:0] iRAW = 12'd0;
    logic [11:0] iGREY = 12'd0;
    logic        iGREY_DVAL = 1'b0;
    logic [11:0] iCONV = 12'd0;
    logic        iCONV_DVAL = 1'b0;
    logic [1:0]  oMODE;
    logic        oCONV_DIR;
    logic        oPIPE_CLR_n;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic        oBUSY;
    logic [15:0] oFRAME_CNT;
    logic        oERR;

    pipe_mode_ctrl #(.IMG_W(W), .IMG_H(H), .FLUSH_CYC(FC)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iMODE_REQ(iMODE_REQ), .iMODE_STB(iMODE_STB),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDVAL(iDVAL), .iRAW(iRAW),
        .iGREY(iGREY), .iGREY_DVAL(iGREY_DVAL), .iCONV(iCONV), .iCONV_DVAL(iCONV_DVAL),
        .oMODE(oMODE), .oCONV_DIR(oCONV_DIR), .oPIPE_CLR_n(oPIPE_CLR_n),
        .oDATA(oDATA), .oDVAL(oDVAL), .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = waiting for SOF, 1 = streaming, 2 = flushing.
    logic [1:0]  m_mode, m_next;
    logic        m_pend;
    int          m_phase;
    int          m_left;
    logic [11:0] m_data;
    logic        m_dval;
    logic [15:0] m_frames;
    logic        m_err;

    // Observations gathered while streaming.
    logic [1:0] pre_eof_mode, eof_mode;
    logic       eof_dir;
    logic       busy_after_s1;
    int         clr_low_cnt = 0;
    int         dval_cnt = 0;

    typedef struct {
        logic        stb;
        logic [1:0]  req;
        logic        dv;
        int          x;
        int          y;
        logic        exp_dval;
        logic [11:0] exp_data;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'd0; m_next = 2'd0; m_pend = 1'b0; m_phase = 0; m_left = 0;
        m_data = 12'd0; m_dval = 1'b0; m_frames = 16'd0; m_err = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic sof, eof, stream, sv;
        logic [11:0] sd;
        sof = iDVAL && int'(iX_Cont) == 0 && int'(iY_Cont) == 0;
        eof = iDVAL && int'(iX_Cont) == W - 1 && int'(iY_Cont) == H - 1;
        stream = (m_phase == 1) || (m_phase == 0 && sof);
        if (m_mode == 2'd0) begin sv = iDVAL; sd = iRAW; end
        else if (m_mode == 2'd1) begin sv = iGREY_DVAL; sd = iGREY; end
        else begin sv = iCONV_DVAL; sd = iCONV; end
        if (stream && sv) begin m_dval = 1'b1; m_data = sd; end
        else m_dval = 1'b0;
        if (iDVAL && (int'(iX_Cont) >= W || int'(iY_Cont) >= H)) m_err = 1'b1;
        if (iMODE_STB) begin
            m_next = iMODE_REQ;
            m_pend = (iMODE_REQ != m_mode);
        end
        if (m_phase == 0) begin
            if (sof) m_phase = 1;
        end else if (m_phase == 1) begin
            if (eof) begin
                m_frames = m_frames + 16'd1;
                if (m_pend) begin
                    m_mode = m_next; m_pend = 1'b0; m_phase = 2; m_left = FC;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
    endtask

    task automatic check_model();
        logic [34:0] act, exp;
        logic e_dir, e_clr, e_busy;
        e_dir  = m_mode[1] & m_mode[0];
        e_clr  = (m_phase != 2);
        e_busy = m_pend || (m_phase == 2);
        act = {oMODE, oCONV_DIR, oPIPE_CLR_n, oDATA, oDVAL, oBUSY, oFRAME_CNT, oERR};
        exp = {m_mode, e_dir, e_clr, m_data, m_dval, e_busy, m_frames, m_err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model t=%0t got mode=%0d dir=%0b clr_n=%0b data=%03h dval=%0b busy=%0b fcnt=%0d err=%0b want mode=%0d dir=%0b clr_n=%0b data=%03h dval=%0b busy=%0b fcnt=%0d err=%0b",
                     $time, oMODE, oCONV_DIR, oPIPE_CLR_n, oDATA, oDVAL, oBUSY, oFRAME_CNT, oERR,
                     m_mode, e_dir, e_clr, m_data, m_dval, e_busy, m_frames, m_err);
        end
    endtask

    // One clock: drive at the falling edge, compare 1 time unit after the rising edge.
    task automatic cycle(input logic stb, input logic [1:0] req, input logic dv, input int x, input int y);
        logic is_eof;
        @(negedge iCLK);
        iMODE_STB  = stb;
        iMODE_REQ  = req;
        iDVAL      = dv;
        iX_Cont    = 11'(x);
        iY_Cont    = 11'(y);
        iRAW       = dv ? 12'(x ^ y) : 12'($urandom);
        iGREY      = 12'($urandom);
        iGREY_DVAL = 1'($urandom_range(0, 1));
        iCONV      = 12'($urandom);
        iCONV_DVAL = 1'($urandom_range(0, 1));
        is_eof     = dv && x == W - 1 && y == H - 1;
        if (is_eof) pre_eof_mode = oMODE;
        model_step();
        @(posedge iCLK);
        #1;
        if (is_eof) begin eof_mode = oMODE; eof_dir = oCONV_DIR; end
        if (!oPIPE_CLR_n) clr_low_cnt++;
        if (oDVAL) dval_cnt++;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 2'd0, 1'b0, 0, 0);
    endtask

    // Stream pixels start_idx..W*H-1; strobes at pixel indices s1/s2 (-1 = none).
    task automatic send_frame(input int s1, input logic [1:0] r1, input int s2, input logic [1:0] r2,
                              input int max_gap, input logic rnd_stb, input int start_idx);
        for (int i = start_idx; i < W * H; i++) begin
            logic stb;
            logic [1:0] req;
            stb = 1'b0; req = 2'd0;
            if (i == s1) begin stb = 1'b1; req = r1; end
            else if (i == s2) begin stb = 1'b1; req = r2; end
            else if (rnd_stb && $urandom_range(0, 39) == 0) begin
                stb = 1'b1; req = 2'($urandom_range(0, 3));
            end
            cycle(stb, req, 1'b1, i % W, i / W);
            if (i == s1) busy_after_s1 = oBUSY;
            if (i % W == W - 1 && max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    // Asynchronous reset applied between clock edges and checked before any edge.
    task automatic reset_pulse();
        #2;
        iRST = 1'b0;
        iMODE_STB = 1'b0;
        iDVAL = 1'b0;
        #1;
        model_reset();
        check("rst_clr_n", 32'(oPIPE_CLR_n), 32'd1);
        check("rst_mode", 32'(oMODE), 32'd0);
        check("rst_fcnt", 32'(oFRAME_CNT), 32'd0);
        check("rst_err", 32'(oERR), 32'd0);
        check_model();
        @(negedge iCLK);
        iRST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 2'd0, 1'b1, 0, 0, 1'b1, 12'h000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 1, 0, 1'b1, 12'h001, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 2, 0, 1'b0, 12'h001, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'd2, 1'b1, 3, 0, 1'b1, 12'h003, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 9, 1, 1'b1, 12'h008, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 2'd0, 1'b0, 0, 0, 1'b0, 12'h008, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 1'b1, 2, 5, 1'b1, 12'h007, 1'b0, 1'b1};

        model_reset();
        reset_pulse();

        // Table: SOF pass-through, hold on invalid, strobe/cancel, range errors.
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].stb, tbl[i].req, tbl[i].dv, tbl[i].x, tbl[i].y);
            check($sformatf("tbl_dval[%0d]", i), 32'(oDVAL), 32'(tbl[i].exp_dval));
            check($sformatf("tbl_data[%0d]", i), 32'(oDATA), 32'(tbl[i].exp_data));
            check($sformatf("tbl_busy[%0d]", i), 32'(oBUSY), 32'(tbl[i].exp_busy));
            check($sformatf("tbl_err[%0d]", i), 32'(oERR), 32'(tbl[i].exp_err));
        end
        send_frame(-1, 2'd0, -1, 2'd0, 1, 1'b0, 0);
        check("err_sticky", 32'(oERR), 32'd1);
        reset_pulse();

        // Two raw frames.
        send_frame(-1, 2'd0, -1, 2'd0, 2, 1'b0, 0);
        send_frame(-1, 2'd0, -1, 2'd0, 2, 1'b0, 0);
        check("raw_fcnt", 32'(oFRAME_CNT), 32'd2);
        check("raw_err", 32'(oERR), 32'd0);

        // Mid-frame request for greyscale.
        clr_low_cnt = 0;
        send_frame(10, 2'd1, -1, 2'd0, 0, 1'b0, 0);
        check("grey_busy_next", 32'(busy_after_s1), 32'd1);
        check("grey_pre_eof_mode", 32'(pre_eof_mode), 32'd0);
        check("grey_eof_mode", 32'(eof_mode), 32'd1);
        idle(20);
        check("grey_clr_len", 32'(clr_low_cnt), 32'(FC));
        check("grey_busy_done", 32'(oBUSY), 32'd0);
        send_frame(-1, 2'd0, -1, 2'd0, 1, 1'b0, 0);
        check("grey_fcnt", 32'(oFRAME_CNT), 32'd4);

        // Two requests in one frame, last wins; next frame starts during the flush.
        clr_low_cnt = 0;
        send_frame(5, 2'd2, 20, 2'd3, 0, 1'b0, 0);
        check("edge_eof_mode", 32'(eof_mode), 32'd3);
        check("edge_eof_dir", 32'(eof_dir), 32'd1);
        cycle(1'b0, 2'd0, 1'b1, 0, 0);
        dval_cnt = 0;
        send_frame(-1, 2'd0, -1, 2'd0, 0, 1'b0, 1);
        check("drop_dval_cnt", 32'(dval_cnt), 32'd0);
        check("drop_fcnt", 32'(oFRAME_CNT), 32'd5);
        idle(10);
        check("edge_clr_len", 32'(clr_low_cnt), 32'(FC));
        send_frame(-1, 2'd0, -1, 2'd0, 1, 1'b0, 0);

        // Back to raw, then a request cancelled within the frame.
        send_frame(3, 2'd0, -1, 2'd0, 0, 1'b0, 0);
        idle(20);
        clr_low_cnt = 0;
        send_frame(5, 2'd1, 15, 2'd0, 0, 1'b0, 0);
        idle(20);
        check("cancel_busy_seen", 32'(busy_after_s1), 32'd1);
        check("cancel_clr_len", 32'(clr_low_cnt), 32'd0);
        check("cancel_mode", 32'(oMODE), 32'd0);
        check("cancel_busy", 32'(oBUSY), 32'd0);

        // Strobe on the EOF pixel itself.
        send_frame(W * H - 1, 2'd2, -1, 2'd0, 0, 1'b0, 0);
        check("eofstb_pre_mode", 32'(pre_eof_mode), 32'd0);
        check("eofstb_eof_mode", 32'(eof_mode), 32'd2);
        idle(20);

        // Reset in the middle of a flush, then resume only at the next SOF.
        send_frame(4, 2'd1, -1, 2'd0, 0, 1'b0, 0);
        idle(5);
        check("midflush_clr_low", 32'(oPIPE_CLR_n), 32'd0);
        reset_pulse();
        dval_cnt = 0;
        send_frame(-1, 2'd0, -1, 2'd0, 0, 1'b0, W);
        check("resume_no_sof", 32'(dval_cnt), 32'd0);
        dval_cnt = 0;
        send_frame(-1, 2'd0, -1, 2'd0, 0, 1'b0, 0);
        check("resume_full", 32'(dval_cnt), 32'(W * H));

        // Randomised frames, gaps and strobes against the model.
        for (int f = 0; f < 40; f++) begin
            send_frame(-1, 2'd0, -1, 2'd0, 3, 1'b1, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 24));
            if (f == 30) cycle(1'b0, 2'd0, 1'b1, W + int'($urandom_range(0, 7)), 0);
        end
        check("rand_err", 32'(oERR), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_mode_ctrl.md
# pipe_mode_ctrl

Frame-synchronous mode controller for the camera filter pipeline. Accepts user mode requests (raw Bayer pass-through, greyscale, horizontal edge, vertical edge) and applies them only at frame boundaries. On each change it flushes the filter datapath (greyscale and convolution line buffers) and then muxes the selected stage output onto the VGA/SDRAM-bound pixel stream. It also counts completed frames and flags out-of-range coordinates.

## Interface
Parameters:
- IMG_W, 1280, active pixels per line
- IMG_H, 960, active lines per frame
- FLUSH_CYC, 16, cycles oPIPE_CLR_n is held low on a mode change (≥1)

Ports:
- iCLK  in  1  pixel clock; the only clock
- iRST  in  1  reset, asynchronous, active-low
- iMODE_REQ  in  2  requested mode: 0 raw, 1 grey, 2 edge-X, 3 edge-Y
- iMODE_STB  in  1  one-cycle strobe qualifying iMODE_REQ (debounced key)
- iX_Cont  in  11  input pixel column
- iY_Cont  in  11  input pixel row
- iDVAL  in  1  input pixel valid
- iRAW  in  12  raw Bayer pixel, aligned with iDVAL
- iGREY  in  12  greyscale stage output
- iGREY_DVAL  in  1  greyscale output valid
- iCONV  in  12  convolution stage output
- iCONV_DVAL  in  1  convolution output valid
- oMODE  out  2  active mode
- oCONV_DIR  out  1  to convolution unit: 0 = X kernel, 1 = Y kernel (= oMODE[0] when oMODE ≥ 2, else 0)
- oPIPE_CLR_n  out  1  active-low synchronous clear to filter stages
- oDATA  out  12  selected pixel
- oDVAL  out  1  oDATA valid
- oBUSY  out  1  mode change pending or in progress
- oFRAME_CNT  out  16  completed frames, wrapping
- oERR  out  1  sticky coordinate-range error

## Operation
- SOF = iDVAL & iX_Cont==0 & iY_Cont==0; EOF = iDVAL & iX_Cont==IMG_W-1 & iY_Cont==IMG_H-1.
- Request capture: on iMODE_STB, next_mode ← iMODE_REQ. pend ← 1 if iMODE_REQ ≠ oMODE, else pend ← 0 (re-request of the current mode cancels a pending change). Strobes are accepted in every state; the latest strobe wins.
- FSM states:
  - WAIT_SOF (reset state): oDVAL=0; on SOF → RUN.
  - RUN: mux active; if pend → PEND.
  - PEND: mux active; on EOF → FLUSH, oMODE ← next_mode, pend ← 0. If pend clears before EOF (cancel) → RUN.
  - FLUSH: oPIPE_CLR_n=0 and oDVAL=0 for FLUSH_CYC cycles, then → WAIT_SOF.
- Mux (RUN/PEND): mode 0 → iRAW/iDVAL; mode 1 → iGREY/iGREY_DVAL; modes 2/3 → iCONV/iCONV_DVAL. oDATA holds its last value when oDVAL=0.
- oBUSY = pend | (state == FLUSH).
- oFRAME_CNT increments on EOF in RUN or PEND only, and wraps 0xFFFF→0.
- oERR set on iDVAL with iX_Cont ≥ IMG_W or iY_Cont ≥ IMG_H, in any state. It is cleared only by reset.
- EOF and iMODE_STB in the same cycle: the strobe updates next_mode/pend first, and that value is applied at this EOF.

## Timing
- Reset values: oMODE=0, oCONV_DIR=0, oPIPE_CLR_n=1, oDATA=0, oDVAL=0, oBUSY=0, oFRAME_CNT=0, oERR=0; state WAIT_SOF, pend=0, next_mode=0.
- Mux latency: one cycle, registered. Source valid at cycle t gives oDVAL at t+1.
- oBUSY rises the cycle after the strobe.
- oMODE updates the cycle after EOF. oPIPE_CLR_n is low from that same cycle for exactly FLUSH_CYC cycles.
- oFRAME_CNT updates the cycle after EOF.
- oERR asserts the cycle after the offending pixel.
- SOF that occurs during FLUSH is ignored: the whole frame is dropped, and the controller resumes at the following SOF.
- Reset mid-frame or mid-flush: all outputs take their reset values immediately (async), and oPIPE_CLR_n returns to 1.

## Test plan
- Reset, then a 2-frame stream with IMG_W=8, IMG_H=4, mode 0, iRAW=x^y → oDATA equals iRAW delayed by 1 cycle; oFRAME_CNT=2; oERR=0.
- Strobe mode 1 mid-frame 0 → oBUSY=1 next cycle; oMODE stays 0 until the cycle after EOF, then becomes 1; oPIPE_CLR_n low exactly 16 cycles; frame 1 passes iGREY; oBUSY=0 after the flush.
- Strobe 2 then strobe 3 in the same frame → oMODE=3 and oCONV_DIR=1 after EOF. Separately, strobe 1 then strobe 0 in one frame → no flush, oMODE stays 0, oBUSY returns to 0.
- Strobe on the exact EOF cycle → change applied at that EOF; oMODE updates the next cycle.
- Apply iDVAL with iX_Cont=8 (IMG_W=8) → oERR=1 next cycle and stays 1 through later frames; reset → oERR=0.
- Assert reset during FLUSH → oPIPE_CLR_n=1, oMODE=0, oFRAME_CNT=0 immediately; output resumes only at the next SOF.
